sccb_config_sequencer: RTL and testbench
========================================

# sccb_config_sequencer

Walks the camera register-configuration table entry by entry and writes each 16-bit {register address, value} pair to the OV-series sensor over a 3-phase SCCB write. It holds off after power-up and after a sensor soft-reset write, then raises `config_done`. It sits between the configuration table (which it addresses through `data_index`) and the top-level SIO_C/SIO_D pins.

## Interface
Parameters:
- `QUARTER_CYC`, default 63: clk cycles per SCCB quarter-bit. At 25 MHz this gives about 100 kHz SIO_C.
- `POWERUP_CYC`, default 25_000_000: wait after reset before the first transaction.
- `SOFT_RST_CYC`, default 25_000: wait after a soft-reset register write.
- `DEV_ADDR`, default 8'h60: SCCB write ID.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `restart` in 1: single-cycle pulse that reruns the full table from index 0. It is honored only when idle or done.
- `data_index` out 8: table entry currently requested.
- `data_out` in 16: table entry, {reg_addr[15:8], value[7:0]}. Combinational from `data_index`.
- `reg_size` in 8: number of table entries.
- `sioc` out 1: SIO_C.
- `siod_out` out 1: SIO_D drive value.
- `siod_oe` out 1: SIO_D output enable. 1 means drive; 0 means release to pull-up.
- `busy` out 1: a sequence is in progress.
- `config_done` out 1: all entries written. It is sticky until `rst` or an accepted `restart`.

## Operation
States and transitions:
- After reset: `PWR_WAIT`.
- `PWR_WAIT` → `FETCH`.
- `FETCH` → `START` → `BITS` → `STOP` → `GAP`.
- `GAP` → `DELAY`, if the entry was a soft reset.
- `GAP` → `FETCH`, if more entries remain.
- `GAP` → `DONE`, if the entry was the last one.
- `DELAY` → `FETCH` or `DONE`.
- `DONE` → `PWR_WAIT` on `restart`.

Per-state behaviour:
- `PWR_WAIT`: count `POWERUP_CYC` cycles. If `reg_size`==0 at expiry, go directly to `DONE`.
- `FETCH` (1 cycle): latch `data_out` into a 27-bit shift register.
  - Layout: {DEV_ADDR, X, reg_addr, X, value, X}, where X is the don't-care bit.
  - Flag a soft reset when `data_out[15:8]`==8'h12 and `data_out[7]`==1.
- `START` (4 quarters):
  - q0–q1: sioc=1, siod=1.
  - q2–q3: sioc=1, siod=0.
- `BITS`: 27 bits, MSB first, 4 quarters each.
  - q0–q1: sioc=0. siod is updated at the start of q0.
  - q2–q3: sioc=1.
  - 9th bit of each phase (bit counts 8, 17, 26): siod_oe=0. The ACK value is not sampled.
- `STOP` (4 quarters):
  - q0: sioc=0, siod=0.
  - q1: sioc=1, siod=0.
  - q2–q3: sioc=1, siod=1.
- `GAP`: 4 quarters of idle bus (sioc=1, siod=1), then `data_index` increments.
- `DELAY`: count `SOFT_RST_CYC` cycles with the bus idle.
- `DONE`: bus idle, `config_done`=1, `busy`=0.

Arithmetic and width rules:
- `data_index` advances from 0 to `reg_size`-1 with no wrap.
- The last entry is the one where `data_index`==`reg_size`-1, compared 8-bit unsigned.
- `data_index` stays at `reg_size`-1 in `DONE`.
- `reg_size` is sampled at `FETCH`. Changing it mid-sequence takes effect at the next `FETCH`.

## Timing
Reset values:
- sioc=1, siod_out=1, siod_oe=1.
- data_index=0, busy=1 (`PWR_WAIT` counts as busy), config_done=0.

Latency:
- Transaction length: 120 quarters = 120·`QUARTER_CYC` clk cycles, from the first `START` cycle to the end of `GAP`.
- `FETCH` adds 1 cycle between transactions.
- First `START` cycle: `POWERUP_CYC`+1 cycles after `rst` deasserts.

Event rules:
- All outputs are registered. sioc and siod never change in the same clk cycle.
- `restart` while busy is ignored.
- `restart` in `DONE` clears `config_done`, zeroes `data_index`, and enters `PWR_WAIT` on the next cycle.
- `rst` mid-transaction: the bus returns to idle on the next cycle. The partial write is abandoned, and the sequence restarts from `PWR_WAIT`.

## Test plan
Common bench settings: `QUARTER_CYC`=2, `POWERUP_CYC`=10, `SOFT_RST_CYC`=20, with a bench ROM.

- **Single entry.** Stimulus: `reg_size`=1, entry 16'h3C32. Required response:
  - SCCB monitor decodes ID 8'h60, address 8'h3C, value 8'h32.
  - siod_oe=0 during bits 8, 17 and 26.
  - config_done rises exactly 10+1+240 cycles after reset release.
- **Three entries.** Stimulus: {FF01, 1101, 0902}. Required response:
  - Three transactions, decoded in order.
  - data_index sequence 0, 1, 2, then it holds at 2.
  - busy=0 and config_done=1 at the end.
- **Soft reset.** Stimulus: table {1280, 1101}. Required response:
  - Exactly 20 extra idle cycles between the end of `GAP` of entry 0 and `FETCH` of entry 1.
  - sioc=1 and siod=1 throughout that gap.
- **Empty table.** Stimulus: `reg_size`=0. Required response:
  - config_done=1 at cycle 11.
  - No sioc toggles.
- **Restart.** Stimulus: `restart` during entry 1 of 3, then `restart` after done. Required response:
  - The first pulse is ignored.
  - The second clears config_done, reruns all three writes, and sets config_done again.
- **Reset mid-transaction.** Stimulus: assert `rst` during bit 12. Required response:
  - Next cycle: sioc=1, siod_out=1, data_index=0, config_done=0.
  - The full sequence reruns correctly after release.

Source files
------------

// File: rtl/sccb_config_sequencer.sv
// Streams {reg_addr, value} entries from the configuration table to an OV-series sensor as
// 3-phase SCCB writes, holding off after power-up and after a sensor soft-reset write.
module sccb_config_sequencer #(
  parameter int unsigned QUARTER_CYC  = 63,
  parameter int unsigned POWERUP_CYC  = 25_000_000,
  parameter int unsigned SOFT_RST_CYC = 25_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic [7:0]  data_index,
  input  logic [15:0] data_out,
  input  logic [7:0]  reg_size,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        config_done
);

  localparam int unsigned WaitMax = (POWERUP_CYC > SOFT_RST_CYC) ? POWERUP_CYC : SOFT_RST_CYC;
  localparam int unsigned WaitW   = (WaitMax > 1) ? $clog2(WaitMax) : 1;
  localparam int unsigned QuartW  = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;

  localparam logic [WaitW-1:0]  PwrLast   = WaitW'(POWERUP_CYC - 1);
  localparam logic [WaitW-1:0]  DlyLast   = WaitW'(SOFT_RST_CYC - 1);
  localparam logic [QuartW-1:0] QuartLast = QuartW'(QUARTER_CYC - 1);

  typedef enum logic [2:0] {
    StPwrWait, StFetch, StStart, StBits, StStop, StGap, StDelay, StDone
  } state_e;

  state_e            state_q;
  logic [WaitW-1:0]  wait_q;
  logic [QuartW-1:0] qcnt_q;
  logic [1:0]        quarter_q;
  logic [4:0]        bit_q;
  logic [26:0]       shift_q;
  logic              soft_rst_q;
  logic              last_q;

  logic q_end;
  logic on_bus;
  logic ack_bit;
  logic last_entry;

  assign q_end      = (qcnt_q == QuartLast);
  assign on_bus     = state_q inside {StStart, StBits, StStop, StGap};
  assign ack_bit    = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
  // A table shrunk below the current index also ends the sequence instead of wrapping.
  assign last_entry = (data_index >= reg_size - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPwrWait;
      wait_q      <= '0;
      qcnt_q      <= '0;
      quarter_q   <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      soft_rst_q  <= 1'b0;
      last_q      <= 1'b0;
      sioc        <= 1'b1;
      siod_out    <= 1'b1;
      siod_oe     <= 1'b1;
      data_index  <= '0;
      busy        <= 1'b1;
      config_done <= 1'b0;
    end else begin
      if (on_bus) begin
        qcnt_q <= q_end ? '0 : qcnt_q + QuartW'(1);
        if (q_end) quarter_q <= quarter_q + 2'd1;
      end

      unique case (state_q)
        StPwrWait: begin
          if (wait_q == PwrLast) begin
            wait_q  <= '0;
            state_q <= StFetch;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StFetch: begin
          // An empty table is caught here, one cycle after the power-up wait expires.
          if (reg_size == 8'd0) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            config_done <= 1'b1;
          end else begin
            shift_q    <= {DEV_ADDR, 1'b0, data_out[15:8], 1'b0, data_out[7:0], 1'b0};
            soft_rst_q <= (data_out[15:8] == 8'h12) && data_out[7];
            last_q     <= last_entry;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (q_end && quarter_q == 2'd1) siod_out <= 1'b0;
          if (q_end && quarter_q == 2'd3) begin
            sioc    <= 1'b0;
            bit_q   <= '0;
            state_q <= StBits;
          end
        end
        StBits: begin
          // SIO_D moves one clk after SIO_C falls (QUARTER_CYC >= 2) so the pins never switch
          // together.
          if (quarter_q == 2'd0 && qcnt_q == '0) begin
            siod_out <= shift_q[26];
            siod_oe  <= !ack_bit;
            shift_q  <= {shift_q[25:0], 1'b0};
          end
          if (q_end && quarter_q == 2'd1) sioc <= 1'b1;
          if (q_end && quarter_q == 2'd3) begin
            sioc <= 1'b0;
            if (bit_q == 5'd26) state_q <= StStop;
            else                bit_q   <= bit_q + 5'd1;
          end
        end
        StStop: begin
          if (quarter_q == 2'd0 && qcnt_q == '0) begin
            siod_out <= 1'b0;
            siod_oe  <= 1'b1;
          end
          if (q_end && quarter_q == 2'd0) sioc     <= 1'b1;
          if (q_end && quarter_q == 2'd1) siod_out <= 1'b1;
          if (q_end && quarter_q == 2'd3) state_q  <= StGap;
        end
        StGap: begin
          if (q_end && quarter_q == 2'd3) begin
            if (!last_q) data_index <= data_index + 8'd1;
            if (soft_rst_q) begin
              state_q <= StDelay;
            end else if (last_q) begin
              state_q     <= StDone;
              busy        <= 1'b0;
              config_done <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StDelay: begin
          if (wait_q == DlyLast) begin
            wait_q <= '0;
            if (last_q) begin
              state_q     <= StDone;
              busy        <= 1'b0;
              config_done <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StDone: begin
          if (restart) begin
            state_q     <= StPwrWait;
            wait_q      <= '0;
            data_index  <= '0;
            busy        <= 1'b1;
            config_done <= 1'b0;
          end
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: an SCCB bus monitor decodes writes and a table-level model
// predicts the decoded writes, completion time and inter-write gaps.
module tb_sccb_config_sequencer;

  localparam int unsigned Q = 2;
  localparam int unsigned P = 10;
  localparam int unsigned S = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic [7:0]  data_index;
  logic [15:0] data_out;
  logic [7:0]  reg_size = 8'd0;
  logic        sioc, siod_out, siod_oe, busy, config_done;
  logic [15:0] rom [256];

  assign data_out = rom[data_index];
  always #5 clk = ~clk;

  sccb_config_sequencer #(
    .QUARTER_CYC (Q),
    .POWERUP_CYC (P),
    .SOFT_RST_CYC(S),
    .DEV_ADDR    (8'h60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .data_index (data_index),
    .data_out   (data_out),
    .reg_size   (reg_size),
    .sioc       (sioc),
    .siod_out   (siod_out),
    .siod_oe    (siod_oe),
    .busy       (busy),
    .config_done(config_done)
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge
  int          mcyc = 0;
  logic        p_sioc = 1'b1, p_siod = 1'b1, p_oe = 1'b1;
  logic [7:0]  p_idx = 8'd0;
  logic        skip = 1'b1, in_frame = 1'b0;
  int          mon_bits = 0;
  logic [26:0] mon_sr = '0, mon_oe = '0, exp_oe;
  int          toggles = 0, skew_errs = 0, ack_errs = 0, idle_errs = 0;
  logic [23:0] obs_q[$];
  int          start_q[$], stop_q[$];
  logic [7:0]  idx_q[$];

  initial begin
    for (int k = 0; k < 27; k++) exp_oe[26-k] = !(k == 8 || k == 17 || k == 26);
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst) begin
        in_frame = 1'b0;
        mon_bits = 0;
        skip = 1'b1;
      end else if (skip) begin
        skip = 1'b0;
      end else begin
        if (sioc != p_sioc) toggles++;
        if (sioc != p_sioc && (siod_out != p_siod || siod_oe != p_oe)) skew_errs++;
        if (data_index != p_idx && data_index != 8'd0) idx_q.push_back(data_index);
        if (!in_frame) begin
          if (sioc && p_sioc && p_siod && !siod_out && siod_oe) begin
            in_frame = 1'b1;
            mon_bits = 0;
            start_q.push_back(mcyc);
          end else if (!sioc || !siod_out || !siod_oe) begin
            idle_errs++;
          end
        end else if (sioc && !p_sioc && mon_bits < 27) begin
          mon_sr = {mon_sr[25:0], siod_out};
          mon_oe = {mon_oe[25:0], siod_oe};
          mon_bits++;
        end else if (mon_bits == 27 && sioc && p_sioc && !p_siod && siod_out) begin
          in_frame = 1'b0;
          stop_q.push_back(mcyc);
          obs_q.push_back({mon_sr[26:19], mon_sr[17:10], mon_sr[8:1]});
          if (mon_oe != exp_oe) ack_errs++;
        end
      end
      p_sioc = sioc;
      p_siod = siod_out;
      p_oe   = siod_oe;
      p_idx  = data_index;
    end
  end

  // Reference model
  function automatic bit is_soft(input logic [15:0] e);
    return (e[15:8] == 8'h12) && e[7];
  endfunction

  function automatic int exp_done(input int n);
    int t;
    if (n == 0) return P + 1;
    t = P;
    for (int i = 0; i < n; i++) t += 1 + 120 * Q + (is_soft(rom[i]) ? S : 0);
    return t;
  endfunction

  int base;
  int s_obs, s_start, s_stop, s_idx, s_tog, s_skew, s_ack, s_idle;

  task automatic snap();
    base    = mcyc;
    s_obs   = obs_q.size();
    s_start = start_q.size();
    s_stop  = stop_q.size();
    s_idx   = idx_q.size();
    s_tog   = toggles;
    s_skew  = skew_errs;
    s_ack   = ack_errs;
    s_idle  = idle_errs;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    snap();
  endtask

  task automatic wait_done(input int budget, output int took);
    int k;
    k = 0;
    while (!config_done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    took = config_done ? (mcyc - base) : -1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_run(input string name, input int n, input int took);
    logic [23:0] e;
    int gap;
    check_eq({name, ":done_t"}, took, exp_done(n));
    check_eq({name, ":n_wr"}, obs_q.size() - s_obs, n);
    for (int i = 0; i < n && s_obs + i < obs_q.size(); i++) begin
      e = {8'h60, rom[i]};
      check_eq({name, ":wr"}, obs_q[s_obs+i], e);
    end
    for (int i = 0; i + 1 < n && s_start + i + 1 < start_q.size()
                             && s_stop + i < stop_q.size(); i++) begin
      gap = 8 * Q + 1 + (is_soft(rom[i]) ? S : 0);
      check_eq({name, ":gap"}, start_q[s_start+i+1] - stop_q[s_stop+i], gap);
    end
    if (n > 0 && s_start < start_q.size())
      check_eq({name, ":first_start"}, start_q[s_start] - base - 1, P + 1 + 2 * Q);
    check_eq({name, ":idx_n"}, idx_q.size() - s_idx, (n > 0) ? n - 1 : 0);
    for (int i = 0; s_idx + i < idx_q.size(); i++)
      check_eq({name, ":idx_seq"}, idx_q[s_idx+i], i + 1);
    check_eq({name, ":toggles"}, toggles - s_tog, 56 * n);
    check_eq({name, ":skew"}, skew_errs - s_skew, 0);
    check_eq({name, ":ack_oe"}, ack_errs - s_ack, 0);
    check_eq({name, ":idle"}, idle_errs - s_idle, 0);
    check_eq({name, ":busy"}, busy, 1'b0);
    check_eq({name, ":index"}, data_index, (n > 0) ? n - 1 : 0);
  endtask

  initial begin
    int took, n, reached;
    logic [15:0] e;

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // Single entry, including reset values
    rom[0] = 16'h3C32;
    reg_size = 8'd1;
    apply_reset();
    check_eq("rst:sioc", sioc, 1'b1);
    check_eq("rst:siod", siod_out, 1'b1);
    check_eq("rst:oe", siod_oe, 1'b1);
    check_eq("rst:index", data_index, 8'd0);
    check_eq("rst:busy", busy, 1'b1);
    check_eq("rst:done", config_done, 1'b0);
    wait_done(2000, took);
    check_run("single", 1, took);

    // Three entries, index holds at the last one
    rom[0] = 16'hFF01; rom[1] = 16'h1101; rom[2] = 16'h0902;
    reg_size = 8'd3;
    apply_reset();
    wait_done(3000, took);
    check_run("three", 3, took);
    repeat (40) @(posedge clk);
    #1;
    check_eq("three:hold_idx", data_index, 8'd2);
    check_eq("three:hold_done", config_done, 1'b1);

    // Soft reset entry
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    reg_size = 8'd2;
    apply_reset();
    wait_done(3000, took);
    check_run("softrst", 2, took);

    // Empty table
    reg_size = 8'd0;
    apply_reset();
    wait_done(200, took);
    check_run("empty", 0, took);

    // Restart: ignored while busy, honoured when done
    rom[0] = 16'hFF01; rom[1] = 16'h1101; rom[2] = 16'h0902;
    reg_size = 8'd3;
    apply_reset();
    reached = 0;
    for (int k = 0; k < 3000 && reached == 0; k++) begin
      if (data_index == 8'd1 && in_frame) reached = 1;
      else begin @(posedge clk); #1; end
    end
    check_eq("rs:reach", reached, 1);
    pulse_restart();
    wait_done(3000, took);
    check_run("rs_busy", 3, took);
    repeat (5) @(posedge clk);
    #1;
    pulse_restart();
    snap();
    check_eq("rs:done_clr", config_done, 1'b0);
    check_eq("rs:idx_clr", data_index, 8'd0);
    check_eq("rs:busy", busy, 1'b1);
    wait_done(3000, took);
    check_run("rs_done", 3, took);

    // Reset during bit 12 of entry 1
    apply_reset();
    reached = 0;
    for (int k = 0; k < 3000 && reached == 0; k++) begin
      if (data_index == 8'd1 && in_frame && mon_bits == 12) reached = 1;
      else begin @(posedge clk); #1; end
    end
    check_eq("rm:reach", reached, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rm:sioc", sioc, 1'b1);
    check_eq("rm:siod", siod_out, 1'b1);
    check_eq("rm:index", data_index, 8'd0);
    check_eq("rm:done", config_done, 1'b0);
    rst = 1'b0;
    snap();
    wait_done(3000, took);
    check_run("rst_mid", 3, took);

    // Randomized tables with occasional soft-reset entries
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        e = 16'($urandom);
        if ($urandom_range(0, 3) == 0) e = {8'h12, 1'b1, e[6:0]};
        rom[i] = e;
      end
      reg_size = 8'(n);
      apply_reset();
      wait_done(exp_done(n) + 200, took);
      check_run("rand", n, took);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
